// File: rtl/alu_sequencer_pkg.sv
// Shared types and constants for the ALU sequencer: opcode map, FSM states,
// datapath widths and small arithmetic helpers.
package alu_sequencer_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned OP_W      = 4;
  localparam int unsigned DIV_ITERS = 32;
  localparam int unsigned CNT_W     = 6;

  localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
  localparam logic [OP_W-1:0] OP_MUL = 4'b0010;
  localparam logic [OP_W-1:0] OP_DIV = 4'b0011;
  localparam logic [OP_W-1:0] OP_AND = 4'b0100;
  localparam logic [OP_W-1:0] OP_OR  = 4'b0101;
  localparam logic [OP_W-1:0] OP_XOR = 4'b0110;
  localparam logic [OP_W-1:0] OP_NOR = 4'b0111;
  localparam logic [OP_W-1:0] OP_SLL = 4'b1000;
  localparam logic [OP_W-1:0] OP_SRL = 4'b1001;
  localparam logic [OP_W-1:0] OP_SRA = 4'b1010;
  localparam logic [OP_W-1:0] OP_RR  = 4'b1011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DIV_RUN,
    ST_DIV_FIX,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } req_t;

  function automatic logic is_legal(input logic [OP_W-1:0] op);
    return op <= OP_RR;
  endfunction

  function automatic logic [DATA_W-1:0] neg32(input logic [DATA_W-1:0] x);
    return ~x + DATA_W'(1);
  endfunction

  // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned 2^31.
  function automatic logic [DATA_W-1:0] abs32(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? neg32(x) : x;
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/result handshake and external-ALU signals of the ALU sequencer.
interface alu_sequencer_if;
  import alu_sequencer_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [OP_W-1:0]   req_op;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic [OP_W-1:0]   alu_control;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_lo;
  logic [DATA_W-1:0] alu_hi;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_lo;
  logic [DATA_W-1:0] res_hi;
  logic              div_by_zero;
  logic              illegal_op;

  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_lo, alu_hi, res_ready,
    output req_ready, alu_control, alu_a, alu_b, res_valid, res_lo, res_hi,
           div_by_zero, illegal_op
  );

  modport master (
    output req_valid, req_op, req_a, req_b, alu_lo, alu_hi, res_ready,
    input  req_ready, alu_control, alu_a, alu_b, res_valid, res_lo, res_hi,
           div_by_zero, illegal_op
  );

endinterface

// File: rtl/alu_sequencer_seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, DIV_ITERS steps.
module alu_sequencer_seq_divider
  import alu_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              last_c
);

  logic [DATA_W-1:0] quot_q, quot_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   diff;

  assign shifted = {rem_q, quot_q[DATA_W-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign last_c  = busy_q && (cnt_q == CNT_W'(DIV_ITERS - 1));

  // Quotient bits shift in at the bottom while dividend bits shift out the top.
  always_comb begin
    quot_d = quot_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      quot_d = dividend;
      rem_d  = '0;
      dvs_d  = divisor;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (!diff[DATA_W]) begin
        rem_d  = diff[DATA_W-1:0];
        quot_d = {quot_q[DATA_W-2:0], 1'b1};
      end else begin
        rem_d  = shifted[DATA_W-1:0];
        quot_d = {quot_q[DATA_W-2:0], 1'b0};
      end
      cnt_d = cnt_q + CNT_W'(1);
      if (last_c) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      quot_q <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one operation at a time through an external combinational ALU,
// with DIV handled by the internal iterative divider.
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic           clk,
  input  logic           clr,
  alu_sequencer_if.slave bus
);

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic              ready_q, ready_d;
  logic [OP_W-1:0]   alu_ctl_q, alu_ctl_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_lo_q, res_lo_d;
  logic [DATA_W-1:0] res_hi_q, res_hi_d;
  logic              dz_q, dz_d;
  logic              ill_q, ill_d;

  logic              accept_c;
  logic              div_start_c;
  logic              div_last_c;
  logic [DATA_W-1:0] quot;
  logic [DATA_W-1:0] rem;

  assign accept_c    = ready_q && bus.req_valid;
  assign div_start_c = accept_c && (bus.req_op == OP_DIV) && (bus.req_b != '0);

  alu_sequencer_seq_divider u_seq_divider (
    .clk       (clk),
    .clr       (clr),
    .start     (div_start_c),
    .dividend  (abs32(bus.req_a)),
    .divisor   (abs32(bus.req_b)),
    .quotient  (quot),
    .remainder (rem),
    .last_c    (div_last_c)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    alu_ctl_d   = alu_ctl_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    res_valid_d = res_valid_q;
    res_lo_d    = res_lo_q;
    res_hi_d    = res_hi_q;
    dz_d        = dz_q;
    ill_d       = ill_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          req_d = '{op: bus.req_op, a: bus.req_a, b: bus.req_b};
          if (is_legal(bus.req_op)) begin
            alu_ctl_d = bus.req_op;
            alu_a_d   = bus.req_a;
            alu_b_d   = bus.req_b;
          end
          // Divide-by-zero skips straight to DONE; DONE raises res_valid a cycle later.
          if (bus.req_op == OP_DIV && bus.req_b == '0) begin
            state_d  = ST_DONE;
            res_lo_d = '1;
            res_hi_d = bus.req_a;
            dz_d     = 1'b1;
          end else if (bus.req_op == OP_DIV) begin
            state_d = ST_DIV_RUN;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        state_d     = ST_DONE;
        res_valid_d = 1'b1;
        if (!is_legal(req_q.op)) begin
          res_lo_d = '0;
          res_hi_d = '0;
          ill_d    = 1'b1;
        end else begin
          res_lo_d = bus.alu_lo;
          res_hi_d = (req_q.op == OP_MUL) ? bus.alu_hi : '0;
        end
      end
      ST_DIV_RUN: begin
        if (div_last_c) state_d = ST_DIV_FIX;
      end
      ST_DIV_FIX: begin
        state_d     = ST_DONE;
        res_valid_d = 1'b1;
        res_lo_d    = (req_q.a[DATA_W-1] ^ req_q.b[DATA_W-1]) ? neg32(quot) : quot;
        res_hi_d    = req_q.a[DATA_W-1] ? neg32(rem) : rem;
      end
      ST_DONE: begin
        if (res_valid_q && bus.res_ready) begin
          state_d     = ST_IDLE;
          res_valid_d = 1'b0;
          dz_d        = 1'b0;
          ill_d       = 1'b0;
        end else begin
          res_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      ready_q     <= 1'b1;
      alu_ctl_q   <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_lo_q    <= '0;
      res_hi_q    <= '0;
      dz_q        <= 1'b0;
      ill_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      ready_q     <= ready_d;
      alu_ctl_q   <= alu_ctl_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      res_valid_q <= res_valid_d;
      res_lo_q    <= res_lo_d;
      res_hi_q    <= res_hi_d;
      dz_q        <= dz_d;
      ill_q       <= ill_d;
    end
  end

  assign bus.req_ready   = ready_q;
  assign bus.alu_control = alu_ctl_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_lo      = res_lo_q;
  assign bus.res_hi      = res_hi_q;
  assign bus.div_by_zero = dz_q;
  assign bus.illegal_op  = ill_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench for alu_sequencer with an external ALU model
// and an arithmetic reference model.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic clk = 1'b0;
  logic clr;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  alu_sequencer_if bus();

  alu_sequencer dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // External ALU: HI carries junk except for MUL; DIV yields junk too.
  function automatic logic [63:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] lo, hi;
    logic [4:0]  sh;
    longint      p;
    sh = b[4:0];
    p  = longint'($signed(a)) * longint'($signed(b));
    lo = 32'h0BAD0BAD;
    hi = 32'hDEADBEEF ^ a;
    case (op)
      OP_ADD: lo = a + b;
      OP_SUB: lo = a - b;
      OP_MUL: begin lo = p[31:0]; hi = p[63:32]; end
      OP_AND: lo = a & b;
      OP_OR:  lo = a | b;
      OP_XOR: lo = a ^ b;
      OP_NOR: lo = ~(a | b);
      OP_SLL: lo = a << sh;
      OP_SRL: lo = a >> sh;
      OP_SRA: lo = $unsigned($signed(a) >>> sh);
      OP_RR:  lo = (a >> sh) | (a << (6'd32 - {1'b0, sh}));
      default: ;
    endcase
    return {hi, lo};
  endfunction

  logic [63:0] alu_out;
  always_comb alu_out = alu_model(bus.alu_control, bus.alu_a, bus.alu_b);
  assign bus.alu_lo = alu_out[31:0];
  assign bus.alu_hi = alu_out[63:32];

  task automatic ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] lo, output logic [31:0] hi,
                           output logic dz, output logic ill, output int lat);
    longint      sa, sb, q, r;
    logic [63:0] o;
    dz = 1'b0; ill = 1'b0; lat = 1;
    if (op > OP_RR) begin
      lo = 32'd0; hi = 32'd0; ill = 1'b1;
    end else if (op == OP_DIV && b == 32'd0) begin
      lo = 32'hFFFFFFFF; hi = a; dz = 1'b1;
    end else if (op == OP_DIV) begin
      sa = longint'($signed(a)); sb = longint'($signed(b));
      q = sa / sb; r = sa % sb;
      lo = q[31:0]; hi = r[31:0]; lat = 33;
    end else begin
      o  = alu_model(op, a, b);
      lo = o[31:0];
      hi = (op == OP_MUL) ? o[63:32] : 32'd0;
    end
  endtask

  // One full request/result transaction; inputs are scrambled right after accept.
  task automatic xact(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input int hold, output logic [31:0] lo, output logic [31:0] hi,
                      output logic dz, output logic ill, output int lat,
                      output bit hold_ok, output bit post_ok);
    int guard;
    guard = 0; hold_ok = 1'b1; post_ok = 1'b1;
    @(negedge clk);
    while (!bus.req_ready && guard < 200) begin @(negedge clk); guard++; end
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_op = 4'($urandom); bus.req_a = $urandom; bus.req_b = $urandom;
    lat = 0;
    while (!bus.res_valid && lat < 100) begin @(posedge clk); lat++; @(negedge clk); end
    lo = bus.res_lo; hi = bus.res_hi; dz = bus.div_by_zero; ill = bus.illegal_op;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      if (bus.res_lo !== lo || bus.res_hi !== hi || bus.div_by_zero !== dz ||
          bus.illegal_op !== ill || bus.res_valid !== 1'b1 || bus.req_ready !== 1'b0)
        hold_ok = 1'b0;
    end
    bus.res_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.res_ready = 1'b0;
    if (bus.res_valid !== 1'b0 || bus.req_ready !== 1'b1 ||
        bus.div_by_zero !== 1'b0 || bus.illegal_op !== 1'b0)
      post_ok = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.res_valid, bus.res_lo, bus.res_hi, bus.div_by_zero, bus.illegal_op,
         bus.alu_control, bus.alu_a, bus.alu_b} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b lo=%h hi=%h dz=%b ill=%b ctl=%h a=%h b=%h, want all zero",
               bus.res_valid, bus.res_lo, bus.res_hi, bus.div_by_zero, bus.illegal_op,
               bus.alu_control, bus.alu_a, bus.alu_b);
    end
    clr = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", bus.req_ready);
    end
  endtask

  task automatic test_add();
    logic [31:0] lo, hi; logic dz, ill; int lat; bit h, p;
    xact(OP_ADD, 32'd5, 32'd7, 0, lo, hi, dz, ill, lat, h, p);
    vectors++;
    if ({lo, hi, dz, ill} !== {32'd12, 32'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL add_result: got lo=%h hi=%h dz=%b ill=%b want lo=0000000c hi=0", lo, hi, dz, ill);
    end
    vectors++;
    if (lat != 1) begin errors++; $display("FAIL add_latency: got %0d want 1", lat); end
    vectors++;
    if (!p) begin errors++; $display("FAIL add_handshake: got bad post-handshake state want idle"); end
  endtask

  task automatic test_mul();
    logic [31:0] lo, hi; logic dz, ill; int lat; bit h, p;
    xact(OP_MUL, 32'hFFFFFFFD, 32'd4, 0, lo, hi, dz, ill, lat, h, p);
    vectors++;
    if ({lo, hi} !== {32'hFFFFFFF4, 32'hFFFFFFFF}) begin
      errors++; $display("FAIL mul_result: got lo=%h hi=%h want lo=fffffff4 hi=ffffffff", lo, hi);
    end
    vectors++;
    if ({bus.alu_control, bus.alu_a, bus.alu_b} !== {OP_MUL, 32'hFFFFFFFD, 32'd4}) begin
      errors++; $display("FAIL alu_hold: got ctl=%h a=%h b=%h want 2 fffffffd 4",
                         bus.alu_control, bus.alu_a, bus.alu_b);
    end
  endtask

  task automatic test_div();
    logic [31:0] lo, hi; logic dz, ill; int lat; bit h, p;
    xact(OP_DIV, 32'hFFFFFFF9, 32'd2, 0, lo, hi, dz, ill, lat, h, p);
    vectors++;
    if ({lo, hi, dz} !== {32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0}) begin
      errors++; $display("FAIL div_neg: got lo=%h hi=%h dz=%b want lo=fffffffd hi=ffffffff dz=0", lo, hi, dz);
    end
    vectors++;
    if (lat != 33) begin errors++; $display("FAIL div_latency: got %0d want 33", lat); end
    xact(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0, lo, hi, dz, ill, lat, h, p);
    vectors++;
    if ({lo, hi, dz, ill} !== {32'h80000000, 32'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL div_overflow: got lo=%h hi=%h dz=%b ill=%b want lo=80000000 hi=0", lo, hi, dz, ill);
    end
  endtask

  task automatic test_div_zero_illegal();
    logic [31:0] lo, hi; logic dz, ill; int lat; bit h, p;
    xact(OP_DIV, 32'd9, 32'd0, 0, lo, hi, dz, ill, lat, h, p);
    vectors++;
    if ({lo, hi, dz, ill} !== {32'hFFFFFFFF, 32'd9, 1'b1, 1'b0} || lat != 1) begin
      errors++; $display("FAIL div_zero: got lo=%h hi=%h dz=%b ill=%b lat=%0d want ffffffff 9 1 0 lat=1",
                         lo, hi, dz, ill, lat);
    end
    vectors++;
    if (!p) begin errors++; $display("FAIL div_zero_clear: got flags not cleared want cleared"); end
    xact(4'b1110, 32'h12345678, 32'h9ABCDEF0, 0, lo, hi, dz, ill, lat, h, p);
    vectors++;
    if ({lo, hi, dz, ill} !== {32'd0, 32'd0, 1'b0, 1'b1} || lat != 1) begin
      errors++; $display("FAIL illegal_op: got lo=%h hi=%h dz=%b ill=%b lat=%0d want 0 0 0 1 lat=1",
                         lo, hi, dz, ill, lat);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] lo, hi; logic dz, ill; int lat; bit h, p;
    xact(OP_OR, 32'hF0, 32'h0F, 10, lo, hi, dz, ill, lat, h, p);
    vectors++;
    if (lo !== 32'hFF) begin errors++; $display("FAIL bp_result: got lo=%h want 000000ff", lo); end
    vectors++;
    if (!h) begin errors++; $display("FAIL bp_hold: got result or ready changed want frozen"); end
    vectors++;
    if (!p) begin errors++; $display("FAIL bp_handshake: got bad post-handshake state want idle"); end
    xact(OP_SUB, 32'd3, 32'd10, 0, lo, hi, dz, ill, lat, h, p);
    vectors++;
    if (lo !== 32'hFFFFFFF9 || lat != 1) begin
      errors++; $display("FAIL back_to_back: got lo=%h lat=%0d want fffffff9 lat=1", lo, lat);
    end
  endtask

  task automatic test_clr_abort();
    logic [31:0] lo, hi; logic dz, ill; int lat; bit h, p, seen;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = OP_DIV; bus.req_a = 32'd100; bus.req_b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    #1;
    vectors++;
    if ({bus.res_valid, bus.res_lo, bus.res_hi, bus.div_by_zero, bus.illegal_op,
         bus.alu_control, bus.alu_a, bus.alu_b} !== '0 || bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL clr_abort: got valid=%b lo=%h hi=%h ctl=%h ready=%b want zeros ready=1",
                         bus.res_valid, bus.res_lo, bus.res_hi, bus.alu_control, bus.req_ready);
    end
    @(negedge clk);
    clr = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (bus.res_valid !== 1'b0) seen = 1'b1; end
    vectors++;
    if (seen) begin errors++; $display("FAIL clr_no_result: got res_valid after abort want 0"); end
    xact(OP_DIV, 32'd100, 32'd3, 0, lo, hi, dz, ill, lat, h, p);
    vectors++;
    if ({lo, hi} !== {32'd33, 32'd1} || lat != 33) begin
      errors++; $display("FAIL clr_redo_div: got lo=%h hi=%h lat=%0d want 21 1 lat=33", lo, hi, lat);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, lo, hi, elo, ehi; logic [3:0] op; logic dz, ill, edz, eill;
    int lat, elat, hold; bit h, p;
    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) op = OP_DIV;
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
      hold = $urandom_range(0, 3);
      ref_model(op, a, b, elo, ehi, edz, eill, elat);
      xact(op, a, b, hold, lo, hi, dz, ill, lat, h, p);
      vectors++;
      if ({lo, hi, dz, ill} !== {elo, ehi, edz, eill}) begin
        errors++; $display("FAIL rand_result op=%h a=%h b=%h: got lo=%h hi=%h dz=%b ill=%b want lo=%h hi=%h dz=%b ill=%b",
                           op, a, b, lo, hi, dz, ill, elo, ehi, edz, eill);
      end
      vectors++;
      if (lat != elat) begin
        errors++; $display("FAIL rand_latency op=%h: got %0d want %0d", op, lat, elat);
      end
      if (hold > 0) begin
        vectors++;
        if (!h) begin errors++; $display("FAIL rand_hold op=%h: got changed want frozen", op); end
      end
      vectors++;
      if (!p) begin errors++; $display("FAIL rand_handshake op=%h: got bad post state want idle", op); end
    end
  endtask

  initial begin
    clr = 1'b1;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_add();
    test_mul();
    test_div();
    test_div_zero_illegal();
    test_backpressure();
    test_clr_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1);
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: none; all widths fixed at 32-bit data, 4-bit opcode.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 clr  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  operation request present.
REQ-005 req_ready  output  1  high only in IDLE; request accepted on an edge where req_valid and req_ready are both high.
REQ-006 req_op  input  4  opcode, ALU encoding (ADD 0000 … RR 1011).
REQ-007 req_a, req_b  input  32 each  signed operands.
REQ-008 alu_control  output  4  opcode driven to external combinational ALU.
REQ-009 alu_a, alu_b  output  32 each  operands driven to external ALU.
REQ-010 alu_lo, alu_hi  input  32 each  external ALU LOW/HIGH result.
REQ-011 res_valid  output  1  result held valid until consumed.
REQ-012 res_ready  input  1  consumer accepts result on an edge where res_valid and res_ready are both high.
REQ-013 res_lo, res_hi  output  32 each  registered result.
REQ-014 div_by_zero, illegal_op  output  1 each  status flags, valid with res_valid.

Function
REQ-015 States: IDLE, ISSUE, DIV_RUN, DIV_FIX, DONE; no other encodings reachable.
REQ-016 IDLE: on accept, register op/A/B; DIV with B≠0 -> DIV_RUN; DIV with B=0 -> DONE; all other ops -> ISSUE.
REQ-017 ISSUE: drive alu_control/alu_a/alu_b from registered values for one cycle; at edge capture alu_lo into res_lo, go to DONE.
REQ-018 res_hi: alu_hi for MUL only; 0 for all other non-DIV ops (external HI never forwarded otherwise).
REQ-019 Non-DIV latency: accept at edge 0, res_valid high after edge 1.
REQ-020 Outside ISSUE, alu_control/alu_a/alu_b hold registered values (no glitch requirement; outputs simply stable).
REQ-021 DIV computed internally, never via external ALU: signed restoring division on magnitudes, one quotient bit per edge, 32 iterations in DIV_RUN (edges 1..32), DIV_FIX at edge 33 applies signs.
REQ-022 DIV result: res_lo = quotient truncated toward zero; res_hi = remainder with sign of dividend; DIV latency res_valid high after edge 33.
REQ-023 DIV overflow: A=0x80000000, B=0xFFFFFFFF -> res_lo 0x80000000, res_hi 0, no flag.
REQ-024 DIV by zero: res_lo 0xFFFFFFFF, res_hi = A, div_by_zero=1, res_valid after edge 1.
REQ-025 Opcodes 1100–1111: no ALU issue; res_lo=res_hi=0, illegal_op=1, res_valid after edge 1.
REQ-026 DONE: res_lo/res_hi/flags frozen while res_ready low; on handshake edge -> IDLE, res_valid low, flags cleared.
REQ-027 No accept in the same cycle as result handshake; next accept earliest one edge after handshake.
REQ-028 req_* inputs ignored outside IDLE; changes mid-operation have no effect.

Reset
REQ-029 clr asserted: state IDLE immediately, any in-flight op aborted with no result produced.
REQ-030 Reset values: req_ready 1 (after clr deasserts), res_valid 0, res_lo/res_hi 0, flags 0, alu_control 0000, alu_a/alu_b 0.

Structure
REQ-031 Shared package holds opcode constants (ADD..RR), state enum, data width 32, iteration count 32.
REQ-032 One sub-module natural: seq_divider (iterative magnitude divider with start/done), instantiated once.

Verification
REQ-033 ADD A=5 B=7, res_ready=1 -> res_lo 12, res_hi 0, res_valid after edge 1.
REQ-034 MUL A=-3 B=4 with ALU model -> res_hi 0xFFFFFFFF, res_lo 0xFFFFFFF4.
REQ-035 DIV A=-7 B=2 -> res_lo 0xFFFFFFFD, res_hi 0xFFFFFFFF, res_valid exactly after edge 33, alu_control never sampled.
REQ-036 DIV A=9 B=0 -> res_lo 0xFFFFFFFF, res_hi 9, div_by_zero 1 after edge 1; opcode 1110 -> illegal_op 1, zeros.
REQ-037 res_ready low 10 cycles after OR 0xF0|0x0F -> res_lo 0xFF held, req_ready low throughout; accept next only after handshake.
REQ-038 clr pulsed at edge 15 of DIV 100/3 -> IDLE, res_valid 0, outputs zero; following DIV 100/3 -> lo 33, hi 1.
